// File: rtl/sram_arbiter_pkg.sv
// Shared video-memory package: arbiter state encoding, bus widths and scroll-address helper.
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_ADDR,
    READ_WAIT_S,
    WRITE_SETUP,
    WRITE_STROBE,
    WRITE_HOLD
  } arb_state_t;

  localparam int READ_WAIT_MAX = 3;
  localparam int ADDR_W        = 17;
  localparam int DATA_W        = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Scrolled scan address; the 17-bit sum wraps around the frame buffer.
  function automatic addr_t scroll_addr(input addr_t base, input addr_t offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-control bundle for sram_arbiter.
// master: video/MPU/fill requesters (and the SRAM side); slave: the arbiter.
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  logic  videoRequest;
  addr_t videoAddress;
  addr_t videoAddressOffset;
  data_t videoData;
  logic  videoDataReady;

  logic  mpuWriteRequest;
  addr_t mpuWriteAddress;
  data_t mpuWriteData;
  logic  mpuWriteComplete;

  logic  fillWriteRequest;
  addr_t fillAddress;
  data_t fillData;
  logic  fillWriteComplete;

  addr_t ramAddress;
  logic  ramWriteEnable;
  logic  ramOutputEnable;

  modport master (
    output videoRequest, videoAddress, videoAddressOffset,
    output mpuWriteRequest, mpuWriteAddress, mpuWriteData,
    output fillWriteRequest, fillAddress, fillData,
    input  videoData, videoDataReady, mpuWriteComplete, fillWriteComplete,
    input  ramAddress, ramWriteEnable, ramOutputEnable
  );

  modport slave (
    input  videoRequest, videoAddress, videoAddressOffset,
    input  mpuWriteRequest, mpuWriteAddress, mpuWriteData,
    input  fillWriteRequest, fillAddress, fillData,
    output videoData, videoDataReady, mpuWriteComplete, fillWriteComplete,
    output ramAddress, ramWriteEnable, ramOutputEnable
  );

endinterface

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: video reads (strobe to data READ_WAIT+2 cycles) beat MPU/fill writes (3 cycles).
// No backpressure on video (one-deep pending, newest wins); writers hold a level request until their complete pulse.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int READ_WAIT = 1
) (
  input  logic         clock,
  input  logic         reset,
  sram_arbiter_if.slave bus,
  inout  wire  [7:0]   ramData
);

  localparam int RW = (READ_WAIT > READ_WAIT_MAX) ? READ_WAIT_MAX :
                      (READ_WAIT < 0)             ? 0 : READ_WAIT;
  localparam logic [1:0] WAIT_LOAD = 2'((RW > 0) ? RW - 1 : 0);

  arb_state_t r_state;
  logic [1:0] r_wait_cnt;
  logic       r_vid_pend;
  addr_t      r_vid_addr;
  logic       r_last_fill;
  logic       r_wr_fill;
  data_t      r_wr_data;
  logic       r_drive;
  addr_t      r_ram_addr;
  logic       r_we_n;
  logic       r_oe_n;
  data_t      r_vid_data;
  logic       r_vid_rdy;
  logic       r_mpu_done;
  logic       r_fill_done;

  addr_t w_vid_eff;
  addr_t w_vid_addr;
  logic  w_vid_go;
  logic  w_wr_go;
  logic  w_pick_fill;
  logic  w_read_last;

  assign w_vid_eff  = scroll_addr(bus.videoAddress, bus.videoAddressOffset);
  // A strobe in the accepting cycle supersedes any older pending address.
  assign w_vid_go   = bus.videoRequest | r_vid_pend;
  assign w_vid_addr = bus.videoRequest ? w_vid_eff : r_vid_addr;
  assign w_wr_go    = bus.mpuWriteRequest | bus.fillWriteRequest;
  assign w_pick_fill = bus.fillWriteRequest & (~bus.mpuWriteRequest | ~r_last_fill);
  assign w_read_last = ((r_state == READ_ADDR) && (RW == 0)) ||
                       ((r_state == READ_WAIT_S) && (r_wait_cnt == 2'd0));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wait_cnt  <= 2'd0;
      r_vid_pend  <= 1'b0;
      r_vid_addr  <= '0;
      r_last_fill <= 1'b1;
      r_wr_fill   <= 1'b0;
      r_wr_data   <= '0;
      r_drive     <= 1'b0;
      r_ram_addr  <= '0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_vid_data  <= '0;
      r_vid_rdy   <= 1'b0;
      r_mpu_done  <= 1'b0;
      r_fill_done <= 1'b0;
    end else begin
      r_vid_rdy   <= 1'b0;
      r_mpu_done  <= 1'b0;
      r_fill_done <= 1'b0;

      if ((r_state == IDLE) && w_vid_go) begin
        r_vid_pend <= 1'b0;
      end else if (bus.videoRequest) begin
        r_vid_pend <= 1'b1;
        r_vid_addr <= w_vid_eff;
      end

      if (w_read_last) begin
        r_vid_data <= ramData;
        r_vid_rdy  <= 1'b1;
        r_oe_n     <= 1'b1;
        r_state    <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_vid_go) begin
              r_ram_addr <= w_vid_addr;
              r_oe_n     <= 1'b0;
              r_state    <= READ_ADDR;
            end else if (w_wr_go) begin
              r_wr_fill   <= w_pick_fill;
              r_last_fill <= w_pick_fill;
              r_ram_addr  <= w_pick_fill ? bus.fillAddress : bus.mpuWriteAddress;
              r_wr_data   <= w_pick_fill ? bus.fillData : bus.mpuWriteData;
              r_drive     <= 1'b1;
              r_state     <= WRITE_SETUP;
            end
          end
          READ_ADDR: begin
            r_wait_cnt <= WAIT_LOAD;
            r_state    <= READ_WAIT_S;
          end
          READ_WAIT_S: r_wait_cnt <= r_wait_cnt - 2'd1;
          WRITE_SETUP: begin
            r_we_n  <= 1'b0;
            r_state <= WRITE_STROBE;
          end
          WRITE_STROBE: begin
            r_we_n      <= 1'b1;
            r_mpu_done  <= ~r_wr_fill;
            r_fill_done <= r_wr_fill;
            r_state     <= WRITE_HOLD;
          end
          WRITE_HOLD: begin
            r_drive <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ramData               = r_drive ? r_wr_data : 8'bz;
  assign bus.ramAddress        = r_ram_addr;
  assign bus.ramWriteEnable    = r_we_n;
  assign bus.ramOutputEnable   = r_oe_n;
  assign bus.videoData         = r_vid_data;
  assign bus.videoDataReady    = r_vid_rdy;
  assign bus.mpuWriteComplete  = r_mpu_done;
  assign bus.fillWriteComplete = r_fill_done;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized reads/writes against a byte-map reference model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int RW = 1;

  logic       clock = 1'b0;
  logic       reset;
  wire  [7:0] ramData;
  int         vectors = 0;
  int         miscompares = 0;

  sram_arbiter_if bus ();

  sram_arbiter #(.READ_WAIT(RW)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .ramData(ramData)
  );

  always #5 clock = ~clock;

  // Asynchronous SRAM: unwritten locations read back a fixed address pattern.
  bit [7:0] mem     [0:131071];
  bit       written [0:131071];

  function automatic logic [7:0] pat(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'hDA;
  endfunction

  wire [7:0] sram_q = written[bus.ramAddress] ? mem[bus.ramAddress] : pat(bus.ramAddress);
  assign ramData = (!bus.ramOutputEnable && bus.ramWriteEnable) ? sram_q : 8'bz;

  always @(posedge clock) begin
    if (bus.ramWriteEnable == 1'b0) begin
      mem[bus.ramAddress]     <= ramData;
      written[bus.ramAddress] <= 1'b1;
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.videoRequest       = 1'b0;
    bus.videoAddress       = 17'h0;
    bus.videoAddressOffset = 17'h0;
    bus.mpuWriteRequest    = 1'b0;
    bus.mpuWriteAddress    = 17'h0;
    bus.mpuWriteData       = 8'h0;
    bus.fillWriteRequest   = 1'b0;
    bus.fillAddress        = 17'h0;
    bus.fillData           = 8'h0;
  endtask

  task automatic test_reset();
    int oe_low;
    oe_low = 0;
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({bus.ramWriteEnable, bus.ramOutputEnable} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_we_oe: got %b expected 11", {bus.ramWriteEnable, bus.ramOutputEnable});
    end
    vectors++;
    if (bus.ramAddress !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_ram_addr: got %h expected 00000", bus.ramAddress);
    end
    vectors++;
    if (bus.videoData !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_video_data: got %h expected 00", bus.videoData);
    end
    vectors++;
    if ({bus.videoDataReady, bus.mpuWriteComplete, bus.fillWriteComplete} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_pulses: got %b expected 000",
               {bus.videoDataReady, bus.mpuWriteComplete, bus.fillWriteComplete});
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.ramOutputEnable !== 1'b1 || bus.ramWriteEnable !== 1'b1) oe_low++;
    end
    vectors++;
    if (oe_low != 0) begin
      miscompares++;
      $display("FAIL reset_idle_quiet: %0d active cycles, expected 0", oe_low);
    end
  endtask

  task automatic test_video_read();
    int lat;
    lat = 0;
    bus.videoAddress       = 17'h00100;
    bus.videoAddressOffset = 17'h1FF80;
    bus.videoRequest       = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        bus.videoRequest = 1'b0;
        vectors++;
        if (bus.ramAddress !== 17'h00080 || bus.ramOutputEnable !== 1'b0 || bus.ramWriteEnable !== 1'b1) begin
          miscompares++;
          $display("FAIL vid_addr_phase: addr %h oe %b we %b, expected 00080 0 1",
                   bus.ramAddress, bus.ramOutputEnable, bus.ramWriteEnable);
        end
      end
      if (bus.videoDataReady === 1'b1) begin
        lat = c;
        break;
      end
    end
    vectors++;
    if (lat != RW + 2) begin
      miscompares++;
      $display("FAIL vid_latency: got %0d expected %0d (0 = never)", lat, RW + 2);
    end
    vectors++;
    if (bus.videoData !== 8'h5A) begin
      miscompares++;
      $display("FAIL vid_data: got %h expected 5a", bus.videoData);
    end
    tick();
    vectors++;
    if (bus.videoDataReady !== 1'b0 || bus.ramOutputEnable !== 1'b1) begin
      miscompares++;
      $display("FAIL vid_ready_pulse: ready %b oe %b, expected 0 1", bus.videoDataReady, bus.ramOutputEnable);
    end
  endtask

  task automatic test_mpu_write();
    int we_low, drv, done_cyc, done_n, fill_n;
    we_low = 0; drv = 0; done_cyc = 0; done_n = 0; fill_n = 0;
    bus.mpuWriteAddress = 17'h12345;
    bus.mpuWriteData    = 8'hA5;
    bus.mpuWriteRequest = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.ramWriteEnable === 1'b0) we_low++;
      if (ramData === 8'hA5 && bus.ramOutputEnable === 1'b1) drv++;
      if (bus.fillWriteComplete === 1'b1) fill_n++;
      if (c == 1) begin
        vectors++;
        if (bus.ramAddress !== 17'h12345 || bus.ramOutputEnable !== 1'b1 || bus.ramWriteEnable !== 1'b1) begin
          miscompares++;
          $display("FAIL wr_setup: addr %h oe %b we %b, expected 12345 1 1",
                   bus.ramAddress, bus.ramOutputEnable, bus.ramWriteEnable);
        end
      end
      if (bus.mpuWriteComplete === 1'b1) begin
        done_n++;
        done_cyc = c;
        bus.mpuWriteRequest = 1'b0;
        vectors++;
        if (bus.ramWriteEnable !== 1'b1 || ramData !== 8'hA5) begin
          miscompares++;
          $display("FAIL wr_hold_phase: we %b data %h, expected 1 a5", bus.ramWriteEnable, ramData);
        end
      end
    end
    vectors++;
    if (we_low != 1) begin
      miscompares++;
      $display("FAIL wr_we_low_cycles: got %0d expected 1", we_low);
    end
    vectors++;
    if (drv != 3) begin
      miscompares++;
      $display("FAIL wr_data_driven_cycles: got %0d expected 3", drv);
    end
    vectors++;
    if (done_n != 1 || done_cyc != 3 || fill_n != 0) begin
      miscompares++;
      $display("FAIL wr_complete: count %0d at cycle %0d fill %0d, expected 1 at 3 fill 0", done_n, done_cyc, fill_n);
    end
    vectors++;
    if (mem[17'h12345] !== 8'hA5) begin
      miscompares++;
      $display("FAIL wr_sram_content: got %h expected a5", mem[17'h12345]);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] grants[$];
    logic [7:0] exp;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mpuWriteAddress  = 17'h00200;
    bus.mpuWriteData     = 8'h11;
    bus.fillAddress      = 17'h00201;
    bus.fillData         = 8'h22;
    bus.mpuWriteRequest  = 1'b1;
    bus.fillWriteRequest = 1'b1;
    for (int c = 0; c < 24 && grants.size() < 4; c++) begin
      tick();
      if (bus.mpuWriteComplete === 1'b1) grants.push_back("M");
      if (bus.fillWriteComplete === 1'b1) grants.push_back("F");
    end
    bus.mpuWriteRequest  = 1'b0;
    bus.fillWriteRequest = 1'b0;
    tick();
    tick();
    vectors++;
    if (grants.size() != 4) begin
      miscompares++;
      $display("FAIL rr_grant_count: got %0d expected 4", grants.size());
    end
    for (int k = 0; k < grants.size(); k++) begin
      exp = (k % 2 == 0) ? "M" : "F";
      vectors++;
      if (grants[k] !== exp) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got %c expected %c", k, grants[k], exp);
      end
    end
    vectors++;
    if (mem[17'h00200] !== 8'h11 || mem[17'h00201] !== 8'h22) begin
      miscompares++;
      $display("FAIL rr_sram_content: got %h %h expected 11 22", mem[17'h00200], mem[17'h00201]);
    end
  endtask

  task automatic test_video_during_write();
    int m_cyc, v_cyc, f_cyc, f_n, strobes, seen;
    logic [7:0]  vdat;
    logic [16:0] rd_addr;
    m_cyc = 0; v_cyc = 0; f_cyc = 0; f_n = 0; strobes = 0; seen = 0;
    vdat = 8'h00; rd_addr = 17'h0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mpuWriteAddress  = 17'h00300;
    bus.mpuWriteData     = 8'h33;
    bus.fillAddress      = 17'h00301;
    bus.fillData         = 8'h44;
    bus.mpuWriteRequest  = 1'b1;
    bus.fillWriteRequest = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.videoRequest = 1'b0;
      if (bus.ramWriteEnable === 1'b0 && strobes == 0) begin
        bus.videoAddress = 17'h00500; bus.videoAddressOffset = 17'h00010;
        bus.videoRequest = 1'b1;
        strobes = 1;
      end else if (strobes == 1) begin
        // Second strobe while the first is still pending: it must win.
        bus.videoAddress = 17'h1FFF0; bus.videoAddressOffset = 17'h00420;
        bus.videoRequest = 1'b1;
        strobes = 2;
      end
      if (bus.ramOutputEnable === 1'b0 && seen == 0) begin
        rd_addr = bus.ramAddress;
        seen = 1;
      end
      if (bus.mpuWriteComplete === 1'b1) begin
        m_cyc = c;
        bus.mpuWriteRequest = 1'b0;
      end
      if (bus.videoDataReady === 1'b1) begin
        v_cyc = c;
        vdat  = bus.videoData;
      end
      if (bus.fillWriteComplete === 1'b1) begin
        f_n++;
        f_cyc = c;
        bus.fillWriteRequest = 1'b0;
      end
    end
    vectors++;
    if (m_cyc != 3) begin
      miscompares++;
      $display("FAIL vdw_mpu_done: cycle %0d expected 3", m_cyc);
    end
    vectors++;
    if (v_cyc != m_cyc + RW + 3) begin
      miscompares++;
      $display("FAIL vdw_video_next: ready at %0d expected %0d", v_cyc, m_cyc + RW + 3);
    end
    vectors++;
    if (rd_addr !== 17'h00410 || vdat !== pat(17'h00410)) begin
      miscompares++;
      $display("FAIL vdw_newest_wins: addr %h data %h, expected 00410 %h", rd_addr, vdat, pat(17'h00410));
    end
    vectors++;
    if (f_n != 1 || f_cyc != v_cyc + 3) begin
      miscompares++;
      $display("FAIL vdw_fill_after: count %0d at %0d, expected 1 at %0d", f_n, f_cyc, v_cyc + 3);
    end
  endtask

  task automatic test_reset_mid_write();
    int found, late;
    found = 0; late = 0;
    bus.fillAddress      = 17'h00600;
    bus.fillData         = 8'h77;
    bus.fillWriteRequest = 1'b1;
    for (int c = 1; c <= 8 && found == 0; c++) begin
      tick();
      if (bus.ramWriteEnable === 1'b0) found = 1;
    end
    vectors++;
    if (found == 0) begin
      miscompares++;
      $display("FAIL rmw_strobe_seen: got 0 expected 1");
    end
    reset = 1'b1;
    bus.fillWriteRequest = 1'b0;
    tick();
    vectors++;
    if (bus.ramWriteEnable !== 1'b1 || bus.ramOutputEnable !== 1'b1) begin
      miscompares++;
      $display("FAIL rmw_we_oe: got %b%b expected 11", bus.ramWriteEnable, bus.ramOutputEnable);
    end
    vectors++;
    if (ramData === 8'h77) begin
      miscompares++;
      $display("FAIL rmw_data_released: got %h, expected bus released", ramData);
    end
    vectors++;
    if (bus.fillWriteComplete !== 1'b0 || bus.mpuWriteComplete !== 1'b0 || bus.ramAddress !== 17'h0) begin
      miscompares++;
      $display("FAIL rmw_reset_state: fill %b mpu %b addr %h, expected 0 0 00000",
               bus.fillWriteComplete, bus.mpuWriteComplete, bus.ramAddress);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.fillWriteComplete === 1'b1 || bus.mpuWriteComplete === 1'b1) late++;
    end
    vectors++;
    if (late != 0) begin
      miscompares++;
      $display("FAIL rmw_no_late_complete: got %0d pulses expected 0", late);
    end
  endtask

  task automatic test_random();
    logic [7:0]  mdl [int];
    logic [16:0] e, o;
    logic [7:0]  wd, exp;
    int kind, lat, done_c, wrong;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      e    = 17'h08000 + 17'($urandom_range(0, 63));
      repeat ($urandom_range(0, 2)) tick();
      if (kind == 0) begin
        o   = 17'($urandom);
        exp = mdl.exists(int'(e)) ? mdl[int'(e)] : pat(e);
        bus.videoAddress       = e - o;
        bus.videoAddressOffset = o;
        bus.videoRequest       = 1'b1;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
          tick();
          if (c == 1) begin
            bus.videoRequest = 1'b0;
            vectors++;
            if (bus.ramAddress !== e) begin
              miscompares++;
              $display("FAIL rnd_rd_addr[%0d]: got %h expected %h", n, bus.ramAddress, e);
            end
          end
          if (bus.videoDataReady === 1'b1) begin
            lat = c;
            break;
          end
        end
        vectors++;
        if (lat != RW + 2 || bus.videoData !== exp) begin
          miscompares++;
          $display("FAIL rnd_rd_data[%0d]: latency %0d data %h, expected %0d %h", n, lat, bus.videoData, RW + 2, exp);
        end
      end else begin
        wd = 8'($urandom);
        if (kind == 1) begin
          bus.mpuWriteAddress = e; bus.mpuWriteData = wd; bus.mpuWriteRequest = 1'b1;
        end else begin
          bus.fillAddress = e; bus.fillData = wd; bus.fillWriteRequest = 1'b1;
        end
        done_c = 0; wrong = 0;
        for (int c = 1; c <= 8; c++) begin
          tick();
          if ((kind == 1 ? bus.fillWriteComplete : bus.mpuWriteComplete) === 1'b1) wrong++;
          if ((kind == 1 ? bus.mpuWriteComplete : bus.fillWriteComplete) === 1'b1) begin
            done_c = c;
            bus.mpuWriteRequest  = 1'b0;
            bus.fillWriteRequest = 1'b0;
            break;
          end
        end
        vectors++;
        if (done_c != 3 || wrong != 0) begin
          miscompares++;
          $display("FAIL rnd_wr[%0d]: complete at %0d wrong-port %0d, expected 3 0", n, done_c, wrong);
        end
        mdl[int'(e)] = wd;
        tick();
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_video_read();
    test_mpu_write();
    test_round_robin();
    test_video_during_write();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
